// File: rtl/dice_roller.sv
// Two-dice roller: synchronized, debounced push-button drives a
// free-running 36-state die pair that freezes when the button is released.
module dice_roller #(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    output logic [2:0] die_a,
    output logic [2:0] die_b,
    output logic [3:0] sum,
    output logic       rolling,
    output logic       roll_done,
    output logic       valid,
    output logic [7:0] roll_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state;
    logic            sync_1;
    logic            btn_s;
    logic            db_state;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_1 <= button;
            btn_s  <= sync_1;
        end
    end

    // Accept a level change only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_state <= 1'b0;
            db_cnt   <= '0;
        end else if (btn_s == db_state) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            db_state <= btn_s;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            die_a      <= 3'd1;
            die_b      <= 3'd1;
            rolling    <= 1'b0;
            roll_done  <= 1'b0;
            valid      <= 1'b0;
            roll_count <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (db_state) begin
                        state   <= ROLLING;
                        rolling <= 1'b1;
                    end
                end
                ROLLING: begin
                    // die_b steps only when die_a wraps, giving a period of 36
                    if (die_a == 3'd6) begin
                        die_a <= 3'd1;
                        die_b <= (die_b == 3'd6) ? 3'd1 : die_b + 3'd1;
                    end else begin
                        die_a <= die_a + 3'd1;
                    end
                    if (!db_state) begin
                        state     <= DONE;
                        rolling   <= 1'b0;
                        roll_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    roll_done  <= 1'b0;
                    valid      <= 1'b1;
                    roll_count <= roll_count + 8'd1;
                end
                default: begin
                    state     <= IDLE;
                    rolling   <= 1'b0;
                    roll_done <= 1'b0;
                end
            endcase
        end
    end

    assign sum = {1'b0, die_a} + {1'b0, die_b};

endmodule
